// File: rtl/nbit_mux_nto1_reg_if.sv
// nbit_mux_nto1_reg_if: bus bundle for the registered N-to-1 mux.
// Carries the per-channel input handshake, the output handshake and the
// selection/status signals. The mux takes the slave view and its
// producers/consumer the master view.
interface nbit_mux_nto1_reg_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          cur_sel;
    logic                      sel_err;

    modport slave (
        input  in_data, in_valid, sel, sel_load, out_ready,
        output in_ready, out_data, out_valid, cur_sel, sel_err
    );

    modport master (
        output in_data, in_valid, sel, sel_load, out_ready,
        input  in_ready, out_data, out_valid, cur_sel, sel_err
    );
endinterface

// File: rtl/nbit_mux_nto1_reg.sv
// nbit_mux_nto1_reg: CHANNELS-way, WIDTH-bit multiplexer with a single
// registered output stage and valid/ready handshaking on every port.
// Build option: define MUX_RR_ARB_EN for round-robin arbitration; otherwise
// the channel is chosen by an externally loaded selection register.
module nbit_mux_nto1_reg #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    nbit_mux_nto1_reg_if.slave  bus
);
    localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             can_accept;
    logic             xfer;

`ifdef MUX_RR_ARB_EN
    // Round-robin grant: first requester scanning up from the last granted channel.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = cur_sel_q;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = (32'(cur_sel_q) + k) % CHANNELS;
            if (!grant_vld && bus.in_valid[idx]) begin
                grant     = SEL_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end
`else
    // External grant: the selection register always names a legal channel.
    always_comb begin
        grant     = cur_sel_q;
        grant_vld = 1'b1;
    end
`endif

    // Route the granted channel's word and drive the per-channel accepts.
    always_comb begin
        can_accept = !out_valid_q || bus.out_ready;
        grant_data = '0;
        bus.in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
                bus.in_ready[i] = !rst && can_accept && grant_vld;
            end
        end
        xfer = |(bus.in_valid & bus.in_ready);
    end

    // Next state of the output stage, the selection register and the error flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cur_sel_d   = cur_sel_q;
        sel_err_d   = 1'b0;

        if (xfer) begin
            out_data_d  = grant_data;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef MUX_RR_ARB_EN
        if (xfer) begin
            cur_sel_d = grant;
        end
`else
        // The transfer above already used the old selection; a load only
        // affects the following cycle.
        if (bus.sel_load) begin
            if (32'(bus.sel) < CHANNELS) begin
                cur_sel_d = bus.sel;
            end else begin
                sel_err_d = 1'b1;
            end
        end
`endif
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cur_sel_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cur_sel_q   <= cur_sel_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cur_sel   = cur_sel_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_nbit_mux_nto1_reg.sv
// Scoreboard bench for nbit_mux_nto1_reg (either build of MUX_RR_ARB_EN).
module tb_nbit_mux_nto1_reg;
    localparam int unsigned W  = 16;
    localparam int unsigned C  = 3;
    localparam int unsigned SW = (C > 2) ? $clog2(C) : 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nbit_mux_nto1_reg_if #(.WIDTH(W), .CHANNELS(C)) bus ();
    nbit_mux_nto1_reg #(.WIDTH(W), .CHANNELS(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] sb[$];
    int unsigned m_sel = 0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: the selected channel, or the first requester after
    // the last grant in round-robin order.
    task automatic model_grant(output int g, output bit ok);
`ifdef MUX_RR_ARB_EN
        ok = 0;
        g  = 0;
        for (int k = 1; k <= int'(C); k++) begin
            int idx;
            idx = (int'(m_sel) + k) % int'(C);
            if (!ok && bus.in_valid[idx]) begin
                g  = idx;
                ok = 1;
            end
        end
`else
        g  = int'(m_sel);
        ok = 1;
`endif
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] d);
        bus.in_data[i*W +: W] = d;
    endtask

    task automatic drive(input logic [C-1:0] v, input logic [W-1:0] d,
                         input logic [SW-1:0] s, input logic sl, input logic ordy);
        bus.in_valid  = v;
        for (int i = 0; i < int'(C); i++) set_ch(i, d ^ W'(16'h1111 * i));
        bus.sel       = s;
        bus.sel_load  = sl;
        bus.out_ready = ordy;
    endtask

    // One cycle: check combinational/state outputs against the model, then
    // predict the handshake and commit it at the clock edge.
    task automatic step();
        int g;
        bit ok, can, xf;
        logic [C-1:0] er;
        logic [W-1:0] d;
        int unsigned nsel;
        logic nerr;
        #2;
        model_grant(g, ok);
        can = (sb.size() == 0) || bus.out_ready;
        er  = '0;
        if (ok && can) er[g] = 1'b1;
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("cur_sel", 64'(bus.cur_sel), 64'(m_sel));
        chk("sel_err", 64'(bus.sel_err), 64'(m_err));
        xf   = ok && can && bus.in_valid[g];
        d    = bus.in_data[g*W +: W];
        nsel = m_sel;
        nerr = 1'b0;
`ifdef MUX_RR_ARB_EN
        if (xf) nsel = int'(g);
`else
        if (bus.sel_load) begin
            if (32'(bus.sel) < C) nsel = 32'(bus.sel);
            else nerr = 1'b1;
        end
`endif
        @(posedge clk);
        if (xf) sb.push_back(d);
        m_sel = nsel;
        m_err = nerr;
        #1;
    endtask

    // Monitor: whenever the DUT presents a word it must be the oldest expected one.
    initial begin
        logic [W-1:0] tmp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
                if (sb.size() != 0) begin
                    chk("out_data", 64'(bus.out_data), 64'(sb[0]));
                    if (bus.out_ready) tmp = sb.pop_front();
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive('1, 16'h5A5A, '0, 1'b0, 1'b1);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data", 64'(bus.out_data), 0);
        chk("rst_cur_sel", 64'(bus.cur_sel), 0);
        chk("rst_sel_err", 64'(bus.sel_err), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b1);

        // Load sel=2, then a single 0xBEEF word from channel 2.
        drive('0, '0, 2'd2, 1'b1, 1'b1); step();
        drive(3'b100, '0, '0, 1'b0, 1'b1); set_ch(2, 16'hBEEF); step();
        drive('0, '0, '0, 1'b0, 1'b1); step();

        // Backpressure: 0x0001 held while the consumer stalls, then 0x0002.
        drive(3'b100, '0, '0, 1'b0, 1'b0); set_ch(2, 16'h0001); step();
        set_ch(2, 16'h0002); step(); step(); step();
        bus.out_ready = 1'b1; step();
        drive('0, '0, '0, 1'b0, 1'b1); step(); step();

        // Illegal selection code.
        drive('0, '0, 2'd3, 1'b1, 1'b1); step();
        drive('0, '0, '0, 1'b0, 1'b1); step(); step();

        // Selection change coinciding with a channel-0 transfer.
        drive('0, '0, 2'd0, 1'b1, 1'b1); step();
        drive(3'b001, 16'h00AA, 2'd1, 1'b1, 1'b1); step();
        drive(3'b011, 16'h0055, '0, 1'b0, 1'b1); step();
        drive('0, '0, '0, 1'b0, 1'b1); step();

        // Every channel requesting, then a lone requester on channel 2.
        for (int i = 0; i < 8; i++) begin drive('1, W'(i * 3 + 7), '0, 1'b0, 1'b1); step(); end
        for (int i = 0; i < 5; i++) begin drive(3'b100, W'(i + 16'h0200), '0, 1'b0, 1'b1); step(); end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(C'($urandom_range(0, (1 << C) - 1)), W'($urandom), SW'($urandom_range(0, (1 << SW) - 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
            step();
        end

        // Mid-stream reset with a word parked in the output register.
        drive('0, '0, 2'd1, 1'b1, 1'b1); step();
        drive('1, 16'h1234, '0, 1'b0, 1'b0); step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
        chk("mid_rst_out_data", 64'(bus.out_data), 0);
        chk("mid_rst_cur_sel", 64'(bus.cur_sel), 0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 0);
        sb.delete();
        m_sel = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_hold_valid", 64'(bus.out_valid), 0);
        rst = 1'b0;
        drive(3'b001, 16'h0C0D, '0, 1'b0, 1'b1); step();
        drive('0, '0, '0, 1'b0, 1'b1); step(); step();

        chk("drain", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
